// File: rtl/bist_receiver.sv
// bist_receiver: checker end of the BIST link.
// Regenerates the sender's Galois LFSR pattern locally, compares every valid
// incoming word against it and accumulates an error count, a sticky
// per-channel fail mask and a final pass verdict.
// Optional feature macro: BIST_RECEIVER_FIRST_FAIL_EN (captures the case
// index of the first failing word on first_fail_index).
module bist_receiver #(
  parameter int unsigned  TEST_CHANNELS = 70,
  parameter logic [31:0]  SEED          = 32'hdeadbeef,
  parameter int unsigned  TEST_CASES    = 1000,
  localparam int unsigned CW            = (TEST_CASES == 0) ? 1 : $clog2(TEST_CASES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [TEST_CHANNELS-1:0] input_channels,
  input  logic                     in_valid,
  output logic                     ready,
  output logic                     pass,
  output logic [CW-1:0]            error_count,
  output logic [TEST_CHANNELS-1:0] error_channels,
  output logic [CW-1:0]            first_fail_index
);

  localparam int unsigned LW = 32;

  // Feedback taps of the right-shifting Galois LFSR shared with the sender.
  localparam logic [LW-1:0] TAPS = 32'h80200003;

  // A zero seed would lock the LFSR at zero; substitute 1 exactly as the sender does.
  localparam logic [LW-1:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;

  // Index of the final case; unused when there are no cases at all.
  localparam logic [CW-1:0] LAST_CASE = (TEST_CASES == 0) ? '0 : CW'(TEST_CASES - 1);

  // Saturation ceiling for the error counter.
  localparam logic [CW-1:0] ERR_MAX = '1;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } state_t;

  // With zero cases the run is trivially complete right out of reset.
  localparam state_t INIT_STATE = (TEST_CASES == 0) ? DONE : RUN;

  state_t                   state;
  logic [LW-1:0]            lfsr;
  logic [CW-1:0]            case_cnt;

  logic [LW-1:0]            lfsr_next_c;
  logic [TEST_CHANNELS-1:0] expected_c;
  logic [TEST_CHANNELS-1:0] mismatch_c;
  logic                     any_mismatch_c;
  logic                     check_c;

  // Next LFSR state: shift right, fold taps in when the bit shifted out is 1.
  always_comb begin
    lfsr_next_c = {1'b0, lfsr[LW-1:1]};
    if (lfsr[0]) begin
      lfsr_next_c = lfsr_next_c ^ TAPS;
    end
  end

  // Expected word: the 32-bit LFSR state replicated across the channel word,
  // the top partial copy taking the low LFSR bits.
  always_comb begin
    expected_c = '0;
    for (int unsigned i = 0; i < TEST_CHANNELS; i++) begin
      expected_c[i] = lfsr[i % LW];
    end
  end

  // Per-word compare against the regenerated pattern.
  always_comb begin
    mismatch_c     = input_channels ^ expected_c;
    any_mismatch_c = |mismatch_c;
    check_c        = (state == RUN) && in_valid;
  end

  // Main checker FSM with registered verdict outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= INIT_STATE;
      lfsr           <= SEED_EFF;
      case_cnt       <= '0;
      error_count    <= '0;
      error_channels <= '0;
      ready          <= 1'b0;
      pass           <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (in_valid) begin
            error_channels <= error_channels | mismatch_c;
            if (any_mismatch_c && (error_count != ERR_MAX)) begin
              error_count <= error_count + CW'(1);
            end
            lfsr     <= lfsr_next_c;
            case_cnt <= case_cnt + CW'(1);
            if (case_cnt == LAST_CASE) begin
              state <= DONE;
              ready <= 1'b1;
              pass  <= (error_count == '0) && !any_mismatch_c;
            end
          end
        end
        DONE: begin
          // Inputs are ignored; verdict holds until the next reset.
          ready <= 1'b1;
          pass  <= (error_count == '0);
        end
        default: begin
          state <= INIT_STATE;
        end
      endcase
    end
  end

`ifdef BIST_RECEIVER_FIRST_FAIL_EN
  logic fail_seen;

  // Latch the case index of the first failing word; the flag blocks later updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      fail_seen        <= 1'b0;
      first_fail_index <= '0;
    end else if (check_c && any_mismatch_c && !fail_seen) begin
      fail_seen        <= 1'b1;
      first_fail_index <= case_cnt;
    end
  end
`else
  // Capture disabled: index is constant zero.
  assign first_fail_index = '0;
`endif

endmodule

// File: doc/bist_receiver.md
Name: bist_receiver

Overview:
- Checker end of the built-in self-test link, paired with bist_sender.
- Regenerates the sender's pseudo-random pattern sequence locally from the same SEED.
- Compares each valid incoming channel word against the expected pattern; accumulates the error count, a sticky per-channel fail mask and a pass verdict.
- Sits at the far side of the network or channel group under test; its outputs feed the top-level BIST status.

Parameters:
- TEST_CHANNELS, 70, width of the channel word under test (>=1).
- SEED, 32'hdeadbeef, initial 32-bit LFSR state; identical to the sender's. SEED==0 is replaced internally by 32'h1.
- TEST_CASES, 1000, number of pattern words to check before completion (>=0).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- input_channels  input  TEST_CHANNELS  received pattern word.
- in_valid  input  1  input_channels holds a pattern word this cycle.
- ready  output  1  checking complete; verdict outputs are final.
- pass  output  1  high only when ready=1 and error_count==0.
- error_count  output  $clog2(TEST_CASES+1) (min 1)  number of words with >=1 mismatching bit.
- error_channels  output  TEST_CHANNELS  sticky OR of all mismatch vectors.
- first_fail_index  output  $clog2(TEST_CASES+1) (min 1)  case index of the first failing word (optional feature).

Behaviour:
- One clock domain. Reset is synchronous and active-high; ports are named clk and reset.
- LFSR: 32-bit Galois, right-shifting; next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
- Expected word: bit i = lfsr[i mod 32].
- Reset values: lfsr=SEED (or 1), case_cnt=0, error_count=0, error_channels=0, first_fail_index=0, ready=0, pass=0.
- FSM states: RUN, DONE. Reset enters RUN, or DONE directly when TEST_CASES==0.
- RUN, on an edge with in_valid=1:
  - mismatch = input_channels ^ expected.
  - error_channels |= mismatch.
  - If |mismatch, error_count += 1.
  - lfsr advances; case_cnt += 1.
  - If case_cnt was TEST_CASES-1, go to DONE.
- RUN with in_valid=0: all state holds; the LFSR does not advance.
- DONE: ready=1. in_valid and input_channels are ignored; all outputs hold until reset.
- ready and pass are registered and rise in the cycle after the edge that sampled the final valid word (1-cycle latency).
- error_count never exceeds TEST_CASES, so no wrap is possible. It is still implemented saturating.
- pass = ready & (error_count==0).
- Reset asserted mid-run aborts the run and restores all reset values on that edge. Reset has priority over in_valid on the same edge.
- TEST_CHANNELS<32: the expected pattern uses lfsr[TEST_CHANNELS-1:0]. TEST_CHANNELS not a multiple of 32: the top partial copy uses the low bits of lfsr.

Optional Feature:
- Macro: BIST_RECEIVER_FIRST_FAIL_EN.
- Defined:
  - On the first failing word, first_fail_index latches that word's case_cnt.
  - A 1-bit flag prevents any further update.
  - The value holds through DONE; it is cleared only by reset.
- Undefined: first_fail_index is tied to 0 and no capture logic is generated.

Test Plan:
- Default params, in_valid=1 every cycle, first word 70'h2F_DEADBEEF_DEADBEEF, second word built from lfsr=32'hEF76DF74, all words correct.
  -> ready rises exactly one cycle after the 1000th valid edge; pass=1; error_count=0; error_channels=0.
- Same stream with in_valid toggling 1/0.
  -> identical verdict; ready after the 1000th valid word, not after the 1000th cycle.
- Flip bit 69 in case 5 and bit 0 in case 7.
  -> error_count=2; error_channels has bits 69 and 0 set; pass=0.
  -> with BIST_RECEIVER_FIRST_FAIL_EN: first_fail_index=5.
- Assert reset for one cycle at case 400, then send a fresh correct stream.
  -> counters clear; the LFSR restarts at SEED; final pass=1 after 1000 further valid words.
- TEST_CASES=0.
  -> ready=1 and pass=1 on the first cycle after reset deasserts.
- TEST_CASES=4, SEED=0, TEST_CHANNELS=8.
  -> expected words use lfsr start 32'h1: 8'h01, then 8'h03 (1>>1 ^ 0x80200003 = 32'h80200003).
  -> a correct stream passes.
